// File: rtl/uart_loader_if.sv
// Memory bus between the boot loader (initiator) and a memory responder.
interface uart_loader_if;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready
  );

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready
  );
endinterface

// File: rtl/uart_loader.sv
// Boot loader: 8N1 UART receiver feeding a frame parser that writes the
// received image word by word onto the memory bus.
module uart_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_loader_if.master bus,
  output logic          loader_done,
  output logic          loader_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_ADDR  = 3'd1;
  localparam logic [2:0] P_CNT   = 3'd2;
  localparam logic [2:0] P_DATA  = 3'd3;
  localparam logic [2:0] P_WRITE = 3'd4;
  localparam logic [2:0] P_CSUM  = 3'd5;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          byte_vld, frame_err;

  logic          buf_full_q, buf_full_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic          pop, overrun;

  logic [2:0]    p_st_q, p_st_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   words_q, words_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic          mvalid_q, mvalid_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          csum_bad;

  logic unused_rdata;
  assign unused_rdata = ^bus.memory_rdata;

  // Receiver: start detected on a synchronized falling edge, then sampled mid-bit.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (rx_st_q)
      R_IDLE: if (!rx_s2_q && rx_s3_q) begin
        rx_st_d  = R_START;
        rx_cnt_d = HALF_BIT;
      end
      R_START: if (rx_cnt_q == '0) begin
        if (rx_s2_q) rx_st_d = R_IDLE;
        else begin
          rx_st_d  = R_DATA;
          rx_cnt_d = FULL_BIT;
          rx_bit_d = 3'd0;
        end
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      R_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_cnt_d = FULL_BIT;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      R_STOP: if (rx_cnt_q == '0) begin
        rx_st_d   = R_IDLE;
        byte_vld  = rx_s2_q;
        frame_err = ~rx_s2_q;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_st_d = R_IDLE;
    endcase
  end

  // One-entry byte buffer; the parser stops draining it while a write is pending.
  always_comb begin
    pop        = buf_full_q && (p_st_q != P_WRITE);
    buf_full_d = buf_full_q & ~pop;
    buf_data_d = buf_data_q;
    overrun    = 1'b0;
    if (byte_vld) begin
      if (buf_full_q && !pop) overrun = 1'b1;
      else begin
        buf_full_d = 1'b1;
        buf_data_d = rx_sh_q;
      end
    end
  end

  always_comb begin
    p_st_d   = p_st_q;
    bcnt_d   = bcnt_q;
    addr_d   = addr_q;
    words_d  = words_q;
    word_d   = word_q;
    csum_d   = csum_q;
    mvalid_d = mvalid_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done_d   = done_q;
    csum_bad = 1'b0;
    case (p_st_q)
      P_IDLE: if (pop && !done_q) begin
        if (buf_data_q == 8'hA5) begin
          p_st_d = P_ADDR;
          bcnt_d = 2'd0;
          csum_d = 8'h00;
        end else if (buf_data_q == 8'h5A) done_d = 1'b1;
      end
      P_ADDR: if (pop) begin
        addr_d = {buf_data_q, addr_q[31:8]};
        csum_d = csum_q ^ buf_data_q;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          p_st_d = P_CNT;
          bcnt_d = 2'd0;
        end
      end
      P_CNT: if (pop) begin
        words_d = {buf_data_q, words_q[15:8]};
        csum_d  = csum_q ^ buf_data_q;
        bcnt_d  = 2'd1;
        if (bcnt_q == 2'd1) begin
          bcnt_d = 2'd0;
          p_st_d = ({buf_data_q, words_q[15:8]} == 16'd0) ? P_CSUM : P_DATA;
        end
      end
      P_DATA: if (pop) begin
        word_d = {buf_data_q, word_q[31:8]};
        csum_d = csum_q ^ buf_data_q;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          p_st_d   = P_WRITE;
          mvalid_d = 1'b1;
          maddr_d  = {addr_q[31:2], 2'b00};
          mwdata_d = {buf_data_q, word_q[31:8]};
        end
      end
      P_WRITE: if (mvalid_q && bus.memory_ready) begin
        mvalid_d = 1'b0;
        addr_d   = addr_q + 32'd4;
        words_d  = words_q - 16'd1;
        bcnt_d   = 2'd0;
        p_st_d   = (words_q == 16'd1) ? P_CSUM : P_DATA;
      end
      P_CSUM: if (pop) begin
        csum_bad = (buf_data_q != csum_q);
        p_st_d   = P_IDLE;
      end
      default: p_st_d = P_IDLE;
    endcase
    err_d = err_q | frame_err | overrun | csum_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      buf_full_q <= 1'b0;
      buf_data_q <= 8'h00;
      p_st_q     <= P_IDLE;
      bcnt_q     <= 2'd0;
      addr_q     <= 32'd0;
      words_q    <= 16'd0;
      word_q     <= 32'd0;
      csum_q     <= 8'h00;
      mvalid_q   <= 1'b0;
      maddr_q    <= 32'd0;
      mwdata_q   <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      p_st_q     <= p_st_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      mvalid_q   <= mvalid_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.memory_valid = mvalid_q;
  assign bus.memory_instr = 1'b0;
  assign bus.memory_addr  = maddr_q;
  assign bus.memory_wdata = mwdata_q;
  assign bus.memory_wstrb = mvalid_q ? 4'hF : 4'h0;
  assign loader_done      = done_q;
  assign loader_error     = err_q;
endmodule

// File: tb/tb_uart_loader.sv
// Directed + randomized frames driven over a UART line; writes captured on
// the bus are checked against expected (address, data) lists built from the frame.
module tb_uart_loader;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic loader_done, loader_error;

  uart_loader_if bus_if ();

  uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus_if),
    .loader_done(loader_done), .loader_error(loader_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder: raises ready ack_dly cycles after it first sees valid, for one cycle.
  int   ack_dly = 1;
  int   ack_w;
  logic rdy;
  always @(posedge clk) begin
    if (rst || !bus_if.memory_valid || rdy) begin
      rdy   <= 1'b0;
      ack_w <= 0;
    end else if (ack_w >= ack_dly - 1) rdy <= 1'b1;
    else ack_w <= ack_w + 1;
  end
  assign bus_if.memory_ready = rdy;
  assign bus_if.memory_rdata = 32'h0;

  logic [31:0] got_a[$], got_d[$];
  int          vlens[$];
  int          stab_evt[$];
  int          vrun;
  logic        pv, pr;
  logic [31:0] pa, pw;

  always @(negedge clk) begin
    if (bus_if.memory_valid && bus_if.memory_ready) begin
      got_a.push_back(bus_if.memory_addr);
      got_d.push_back(bus_if.memory_wdata);
    end
    if (bus_if.memory_valid) vrun <= vrun + 1;
    else begin
      if (vrun > 0) vlens.push_back(vrun);
      vrun <= 0;
    end
    if (bus_if.memory_valid && pv && !pr &&
        (bus_if.memory_addr != pa || bus_if.memory_wdata != pw)) stab_evt.push_back(1);
    if (bus_if.memory_wstrb != (bus_if.memory_valid ? 4'hF : 4'h0)) stab_evt.push_back(2);
    if (bus_if.memory_instr !== 1'b0) stab_evt.push_back(3);
    pv <= bus_if.memory_valid;
    pr <= bus_if.memory_ready;
    pa <= bus_if.memory_addr;
    pw <= bus_if.memory_wdata;
  end

  logic [7:0]  bq[$];
  logic [31:0] wq[$];
  logic [31:0] ea[$], ed[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: frame bytes and the writes they must produce.
  task automatic build_frame(input logic [31:0] base, input logic [7:0] cx);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(wq.size());
    cs = 8'h00;
    bq.delete(); ea.delete(); ed.delete();
    bq.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin b = base[8*k +: 8]; bq.push_back(b); cs ^= b; end
    for (int k = 0; k < 2; k++) begin b = n[8*k +: 8]; bq.push_back(b); cs ^= b; end
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      for (int k = 0; k < 4; k++) begin b = w[8*k +: 8]; bq.push_back(b); cs ^= b; end
      ea.push_back({base[31:2], 2'b00} + 32'(4 * i));
      ed.push_back(w);
    end
    bq.push_back(cs ^ cx);
  endtask

  task automatic bit_t(input logic v);
    @(negedge clk);
    rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
    bit_t(stop);
    bit_t(1'b1);
  endtask

  task automatic send_bq(input int glitch_at, input int badstop_at);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == glitch_at) begin
        @(negedge clk); rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
      end
      send_byte(bq[i], i != badstop_at);
    end
    repeat (100) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_a.delete(); got_d.delete(); vlens.delete(); stab_evt.delete();
  endtask

  task automatic chk_writes(input string tag);
    chk($sformatf("%s_nwrites", tag), 32'(got_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      if (i < got_a.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), got_a[i], ea[i]);
        chk($sformatf("%s_data%0d", tag, i), got_d[i], ed[i]);
      end
    chk($sformatf("%s_stable", tag), 32'(stab_evt.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus_if.memory_valid), 32'd0);
    chk({tag, "_wstrb"}, 32'(bus_if.memory_wstrb), 32'd0);
    chk({tag, "_addr"},  bus_if.memory_addr, 32'd0);
    chk({tag, "_wdata"}, bus_if.memory_wdata, 32'd0);
    chk({tag, "_instr"}, 32'(bus_if.memory_instr), 32'd0);
    chk({tag, "_done"},  32'(loader_done), 32'd0);
    chk({tag, "_error"}, 32'(loader_error), 32'd0);
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("reset");
    clear_mon();

    // Basic two-word frame, one-cycle ack.
    wq = '{32'h12345678, 32'hDEADBEEF};
    build_frame(32'h00001000, 8'h00);
    send_bq(-1, -1);
    chk_writes("basic");
    chk("basic_nvld", 32'(vlens.size()), 32'd2);
    foreach (vlens[i]) chk($sformatf("basic_vlen%0d", i), 32'(vlens[i]), 32'd2);
    chk("basic_err", 32'(loader_error), 32'd0);
    chk("basic_done", 32'(loader_done), 32'd0);

    // Slow responder: outputs held, one write per word.
    clear_mon(); ack_dly = 40;
    send_bq(-1, -1);
    chk_writes("slow");
    foreach (vlens[i]) chk($sformatf("slow_vlen%0d", i), 32'(vlens[i]), 32'd41);
    chk("slow_err", 32'(loader_error), 32'd0);

    // Bad checksum: writes still land, error raised, then end frame.
    clear_mon(); ack_dly = 1;
    build_frame(32'h00001000, 8'h01);
    send_bq(-1, -1);
    chk_writes("badcs");
    chk("badcs_err", 32'(loader_error), 32'd1);
    chk("badcs_done", 32'(loader_done), 32'd0);
    bq = '{8'h5A};
    send_bq(-1, -1);
    chk("end_done", 32'(loader_done), 32'd1);
    clear_mon();
    build_frame(32'h00002000, 8'h00);
    send_bq(-1, -1);
    chk("after_done_nwrites", 32'(got_a.size()), 32'd0);

    // Address wrap, base low bits ignored.
    do_reset();
    wq = '{32'hCAFEF00D, 32'h0BADC0DE};
    build_frame(32'hFFFFFFFE, 8'h00);
    send_bq(-1, -1);
    chk_writes("wrap");
    chk("wrap_err", 32'(loader_error), 32'd0);

    // Randomized frames against the model.
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      ack_dly = $urandom_range(1, 5);
      wq.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) wq.push_back($urandom);
      build_frame($urandom, 8'h00);
      send_bq(-1, -1);
      chk_writes($sformatf("rand%0d", t));
      chk($sformatf("rand%0d_err", t), 32'(loader_error), 32'd0);
    end

    // Start glitch after the header must not be taken as a byte.
    clear_mon(); ack_dly = 1;
    wq = '{32'h01020304};
    build_frame(32'h00000040, 8'h00);
    send_bq(1, -1);
    chk_writes("glitch");
    chk("glitch_err", 32'(loader_error), 32'd0);

    // Framing error on an address byte.
    clear_mon();
    send_bq(-1, 2);
    chk("badstop_err", 32'(loader_error), 32'd1);

    // Overrun while the bus stalls.
    do_reset();
    chk("pre_overrun_err", 32'(loader_error), 32'd0);
    ack_dly = 400;
    wq = '{32'h11111111, 32'h22222222, 32'h33333333};
    build_frame(32'h00000100, 8'h00);
    send_bq(-1, -1);
    chk("overrun_err", 32'(loader_error), 32'd1);

    // Reset during a pending request, then a clean reload.
    do_reset();
    ack_dly = 400;
    wq = '{32'hA0A0A0A0};
    build_frame(32'h00000200, 8'h00);
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], 1'b1);
    budget = 2000;
    while (!bus_if.memory_valid && budget > 0) begin @(negedge clk); budget--; end
    chk("rst_valid_seen", 32'(bus_if.memory_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    clear_mon(); ack_dly = 1;
    wq = '{32'h5555AAAA, 32'h76543210};
    build_frame(32'h00003000, 8'h00);
    send_bq(-1, -1);
    chk_writes("reload");
    chk("reload_err", 32'(loader_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
